// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller state encoding, sizes and round constants.
package aes_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned AES_IDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KCLR   = 3'd1,
        ST_KBEGIN = 3'd2,
        ST_LOAD   = 3'd3,
        ST_ROUND  = 3'd4,
        ST_OUT    = 3'd5
    } aes_ctrl_state_t;

    // Key-schedule round constants, entry i used for round key i+1.
    localparam logic [7:0] AES_RCON [AES_NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

endpackage

// File: rtl/aes_core_ctrl.sv
// Sequencer for the AES-128 encrypt core: host handshake, key caching,
// key-expansion restart and round issue gated by per-round-key done flags.
module aes_core_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR    = AES_NR,
    parameter int unsigned BLK_W = AES_BLK_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [BLK_W-1:0] key_i,
    input  logic [BLK_W-1:0] block_i,
    input  logic             key_flush_i,
    output logic             kexp_clr_o,
    output logic             kexp_begin_o,
    input  logic [NR:0]      kexp_done_i,
    output logic             dp_load_o,
    output logic             dp_round_en_o,
    output logic [3:0]       dp_round_idx_o,
    output logic             dp_final_o,
    output logic [BLK_W-1:0] block_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o
);

    localparam logic [AES_IDX_W-1:0] LAST_IDX = AES_IDX_W'(NR);

    aes_ctrl_state_t        r_state;
    aes_ctrl_state_t        w_state_nxt;
    logic [AES_IDX_W-1:0]   r_idx;
    logic                   r_key_cached;
    logic [BLK_W-1:0]       r_key;
    logic [BLK_W-1:0]       r_block;

    logic                   w_accept;
    logic                   w_key_hit;
    logic                   w_done_cur;

    // A flush in the accept cycle forces the miss path.
    assign w_accept   = in_valid_i && (r_state == ST_IDLE);
    assign w_key_hit  = r_key_cached && !key_flush_i && (key_i == r_key);
    assign w_done_cur = kexp_done_i[r_idx];
    assign block_o    = r_block;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (in_valid_i) w_state_nxt = w_key_hit ? ST_LOAD : ST_KCLR;
            ST_KCLR:   w_state_nxt = ST_KBEGIN;
            ST_KBEGIN: w_state_nxt = ST_LOAD;
            ST_LOAD:   if (w_done_cur) w_state_nxt = ST_ROUND;
            ST_ROUND:  if (w_done_cur && (r_idx == LAST_IDX)) w_state_nxt = ST_OUT;
            ST_OUT:    if (out_ready_i) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; strobes are mutually exclusive because each belongs to one state.
    always_comb begin
        in_ready_o     = 1'b0;
        busy_o         = 1'b1;
        kexp_clr_o     = 1'b0;
        kexp_begin_o   = 1'b0;
        dp_load_o      = 1'b0;
        dp_round_en_o  = 1'b0;
        dp_final_o     = 1'b0;
        dp_round_idx_o = 4'd0;
        out_valid_o    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
            end
            ST_KCLR:   kexp_clr_o   = 1'b1;
            ST_KBEGIN: kexp_begin_o = 1'b1;
            ST_LOAD: begin
                dp_round_idx_o = 4'd0;
                dp_load_o      = w_done_cur;
            end
            ST_ROUND: begin
                dp_round_idx_o = 4'(r_idx);
                dp_round_en_o  = w_done_cur;
                dp_final_o     = w_done_cur && (r_idx == LAST_IDX);
            end
            ST_OUT:    out_valid_o = 1'b1;
            default: begin
                in_ready_o = 1'b0;
                busy_o     = 1'b1;
            end
        endcase
    end

    // Request capture and round index; index parks at NR and never wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_key   <= '0;
            r_block <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_key   <= key_i;
            r_block <= block_i;
            r_idx   <= '0;
        end else if ((r_state == ST_LOAD) && w_done_cur) begin
            r_idx <= AES_IDX_W'(1);
        end else if ((r_state == ST_ROUND) && w_done_cur && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + AES_IDX_W'(1);
        end
    end

    // Key cache valid: set once expansion is started for the captured key, cleared by flush or miss.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_key_cached <= 1'b0;
        end else if (key_flush_i) begin
            r_key_cached <= 1'b0;
        end else if (w_accept && !w_key_hit) begin
            r_key_cached <= 1'b0;
        end else if (r_state == ST_KBEGIN) begin
            r_key_cached <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Self-checking bench for aes_core_ctrl with behavioural key-expansion and round datapath.
`timescale 1ns/1ps
module tb_aes_core_ctrl;
    import aes_pkg::*;

    localparam int unsigned NR = AES_NR;
    localparam int unsigned BW = AES_BLK_W;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [BW-1:0] key_i;
    logic [BW-1:0] block_i;
    logic          key_flush_i;
    logic          kexp_clr_o;
    logic          kexp_begin_o;
    logic [NR:0]   kexp_done_i;
    logic          dp_load_o;
    logic          dp_round_en_o;
    logic [3:0]    dp_round_idx_o;
    logic          dp_final_o;
    logic [BW-1:0] block_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          busy_o;

    aes_core_ctrl #(.NR(NR), .BLK_W(BW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .key_i(key_i), .block_i(block_i), .key_flush_i(key_flush_i),
        .kexp_clr_o(kexp_clr_o), .kexp_begin_o(kexp_begin_o), .kexp_done_i(kexp_done_i),
        .dp_load_o(dp_load_o), .dp_round_en_o(dp_round_en_o), .dp_round_idx_o(dp_round_idx_o),
        .dp_final_o(dp_final_o), .block_o(block_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- AES reference ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] rkey(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {AES_RCON[i/4-1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            if (fin) begin
                for (int r = 0; r < 4; r++) a[r+4*c] = b[r+4*c];
            end else begin
                a[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
                a[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rkey(key, 0);
        for (int r = 1; r <= 10; r++) s = aes_round(s, rkey(key, r), r == 10);
        return s;
    endfunction

    // ---------------- key-expansion and datapath models ----------------
    logic           m_act = 1'b0;
    int             m_t = 0;
    int             kexp_gap = 0;
    logic [127:0]   m_rk [NR+1];
    logic [127:0]   m_st;
    logic [127:0]   acc_key;

    // Round key k becomes ready kexp_gap*k cycles after the first post-begin cycle.
    always @(posedge clk_i) begin
        if (rst_i || kexp_clr_o) begin
            m_act <= 1'b0;
        end else if (kexp_begin_o) begin
            m_act <= 1'b1;
            m_t   <= 0;
            for (int r = 0; r <= int'(NR); r++) m_rk[r] <= rkey(acc_key, r);
        end else if (m_act && m_t < 10000) begin
            m_t <= m_t + 1;
        end
    end

    always_comb begin
        kexp_done_i = '0;
        for (int k = 0; k <= int'(NR); k++) kexp_done_i[k] = m_act && (m_t >= k * kexp_gap);
    end

    always @(posedge clk_i) begin
        if (dp_load_o) m_st <= block_o ^ m_rk[0];
        else if (dp_round_en_o) m_st <= aes_round(m_st, m_rk[dp_round_idx_o], dp_final_o);
    end

    // ---------------- protocol monitor and scoreboard ----------------
    logic [127:0] sb_q [$];
    int   n_clr = 0;
    int   n_begin = 0;
    int   exp_next = 0;
    logic prev_ov = 1'b0;
    logic prev_or = 1'b0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            sb_q.delete();
            prev_ov = 1'b0;
            prev_or = 1'b0;
        end else begin
            if (kexp_clr_o) n_clr++;
            if (kexp_begin_o) n_begin++;
            if (in_valid_i && in_ready_o) begin
                acc_key = key_i;
                sb_q.push_back(aes_enc(key_i, block_i));
            end
            if (dp_load_o || dp_round_en_o || kexp_clr_o || kexp_begin_o)
                chk("strobe_onehot",
                    128'($countones({dp_load_o, dp_round_en_o, kexp_clr_o, kexp_begin_o})), 128'd1);
            if (dp_load_o) begin
                chk("load_done0", 128'(kexp_done_i[0]), 128'd1);
                chk("load_idx", 128'(dp_round_idx_o), 128'd0);
                exp_next = 1;
            end
            if (dp_round_en_o) begin
                chk("round_done_flag", 128'(kexp_done_i[dp_round_idx_o]), 128'd1);
                chk("round_idx_seq", 128'(dp_round_idx_o), 128'(exp_next));
                chk("final_flag", 128'(dp_final_o), 128'(dp_round_idx_o == 4'(NR)));
                exp_next++;
            end else if (dp_final_o) begin
                chk("final_without_round", 128'(dp_final_o), 128'd0);
            end
            if (prev_ov && !prev_or) chk("out_valid_hold", 128'(out_valid_o), 128'd1);
            if (out_valid_o && out_ready_i) begin
                chk("sb_has_entry", 128'(sb_q.size() > 0), 128'd1);
                if (sb_q.size() > 0) chk("ciphertext", m_st, sb_q.pop_front());
            end
            prev_ov = out_valid_o;
            prev_or = out_ready_i;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        int           gap;
        int           hold;
        bit           flush;
        int           lat;
        bit           kexp;
        bit           use_ct;
        logic [127:0] ct;
    } vec_t;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K3  = 128'hdeadbeef0123456789abcdeffedcba98;

    // One request: drive, measure accept-to-out_valid latency, hold, handshake.
    task automatic apply(input vec_t v, input string nm);
        int  c0;
        int  b0;
        int  lat;
        if (v.kexp) kexp_gap = v.gap;
        c0 = n_clr;
        b0 = n_begin;
        chk({nm, "_in_ready"}, 128'(in_ready_o), 128'd1);
        key_i       = v.key;
        block_i     = v.pt;
        in_valid_i  = 1'b1;
        key_flush_i = v.flush;
        @(posedge clk_i); #1;
        in_valid_i  = 1'b0;
        key_flush_i = 1'b0;
        lat = 1;
        for (int n = 0; n < 300; n++) begin
            if (out_valid_o) break;
            @(posedge clk_i); #1;
            lat++;
        end
        chk({nm, "_latency"}, 128'(lat), 128'(v.lat));
        for (int h = 0; h < v.hold; h++) begin
            chk({nm, "_hold_valid"}, 128'(out_valid_o), 128'd1);
            chk({nm, "_hold_ready"}, 128'(in_ready_o), 128'd0);
            @(posedge clk_i); #1;
        end
        if (v.use_ct) chk({nm, "_ct"}, m_st, v.ct);
        chk({nm, "_kexp_clr_cnt"}, 128'(n_clr - c0), 128'(v.kexp));
        chk({nm, "_kexp_begin_cnt"}, 128'(n_begin - b0), 128'(v.kexp));
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        chk({nm, "_ready_after"}, 128'(in_ready_o), 128'd1);
        chk({nm, "_valid_after"}, 128'(out_valid_o), 128'd0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_in_ready"}, 128'(in_ready_o), 128'd1);
        chk({nm, "_strobes"}, 128'({kexp_clr_o, kexp_begin_o, dp_load_o, dp_round_en_o,
                                    dp_final_o, out_valid_o, busy_o}), 128'd0);
        chk({nm, "_idx"}, 128'(dp_round_idx_o), 128'd0);
        chk({nm, "_block"}, block_o, 128'd0);
    endtask

    vec_t vecs [9];

    initial begin
        logic [7:0] inv;
        bit         found;
        bit         ov_seen;
        int         lat;
        vec_t       v;

        vecs[0] = '{K1, P1, 0, 0,  1'b0, 14, 1'b1, 1'b1, C1};
        vecs[1] = '{K1, P1, 0, 0,  1'b0, 12, 1'b0, 1'b1, C1};
        vecs[2] = '{K1, P2, 0, 0,  1'b0, 12, 1'b0, 1'b0, '0};
        vecs[3] = '{K2, P2, 4, 0,  1'b0, 44, 1'b1, 1'b1, C2};
        vecs[4] = '{K2, P1, 0, 20, 1'b0, 12, 1'b0, 1'b0, '0};
        vecs[5] = '{K2, P2, 0, 0,  1'b1, 14, 1'b1, 1'b1, C2};
        vecs[6] = '{K3, P1, 1, 0,  1'b0, 14, 1'b1, 1'b0, '0};
        vecs[7] = '{K3, P2, 0, 3,  1'b0, 12, 1'b0, 1'b0, '0};
        vecs[8] = '{K1, P1, 2, 0,  1'b0, 24, 1'b1, 1'b1, C1};

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        key_i       = '0;
        block_i     = '0;
        key_flush_i = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_outputs("reset");
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 9; i++) apply(vecs[i], $sformatf("v%0d", i));

        // Flush mid-round: in-flight block still finishes with the cached key.
        key_i      = K1;
        block_i    = P2;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        lat = 1;
        repeat (4) begin @(posedge clk_i); #1; lat++; end
        key_flush_i = 1'b1;
        @(posedge clk_i); #1;
        lat++;
        key_flush_i = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (out_valid_o) break;
            @(posedge clk_i); #1;
            lat++;
        end
        chk("flush_inflight_latency", 128'(lat), 128'd12);
        chk("flush_inflight_ct", m_st, aes_enc(K1, P2));
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        v = '{K1, P1, 0, 0, 1'b0, 14, 1'b1, 1'b1, C1};
        apply(v, "after_flush");

        // Reset during round 5 abandons the block.
        key_i      = K1;
        block_i    = P2;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (dp_round_en_o && dp_round_idx_o == 4'd5) begin
                found = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        chk("reach_round5", 128'(found), 128'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk_reset_outputs("midrun_reset");
        rst_i = 1'b0;
        ov_seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk_i); #1;
            if (out_valid_o) ov_seen = 1'b1;
        end
        chk("no_out_after_reset", 128'(ov_seen), 128'd0);
        v = '{K1, P1, 0, 0, 1'b0, 14, 1'b1, 1'b1, C1};
        apply(v, "after_reset");

        repeat (2) @(posedge clk_i);
        #1;
        chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
